// File: rtl/mips_multicycle_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mips_multicycle_ctrl: multicycle MIPS control FSM (lw/sw/R/beq/addi/j)      |
// | with memory wait counting, timeout abort and sticky error flags.           |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mips_multicycle_ctrl #(
  parameter int WAIT_LIMIT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_src,
  output logic [3:0] state,
  output logic       instr_done,
  output logic       illegal_op,
  output logic       mem_timeout
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,  DECODE = 4'd1,  MEMADR = 4'd2,  MEMRD  = 4'd3,
    MEMWB  = 4'd4,  MEMWR  = 4'd5,  EXEC   = 4'd6,  ALUWB  = 4'd7,
    BRANCH = 4'd8,  ADDIEX = 4'd9,  ADDIWB = 4'd10, JUMP   = 4'd11
  } state_t;

  localparam logic [5:0] c_opLw   = 6'b100011;
  localparam logic [5:0] c_opSw   = 6'b101011;
  localparam logic [5:0] c_opR    = 6'b000000;
  localparam logic [5:0] c_opBeq  = 6'b000100;
  localparam logic [5:0] c_opAddi = 6'b001000;
  localparam logic [5:0] c_opJ    = 6'b000010;
  localparam logic [7:0] c_waitLast = 8'(WAIT_LIMIT - 1);

  state_t     r_state;
  state_t     w_nextState;
  logic [7:0] r_waitCnt;
  logic       r_instrDone;
  logic       r_illegalOp;
  logic       r_memTimeout;
  logic       w_waiting;
  logic       w_timeout;
  logic       w_badOp;
  logic       w_retire;

  // Memory-access states stalled on mem_ready; ready always beats timeout.
  assign w_waiting = !mem_ready &&
                     ((r_state == FETCH && run) || r_state == MEMRD || r_state == MEMWR);
  assign w_timeout = w_waiting && (r_waitCnt == c_waitLast);

  always_comb begin
    w_nextState = r_state;
    w_badOp     = 1'b0;
    case (r_state)
      FETCH:  w_nextState = (run && mem_ready) ? DECODE : FETCH;
      DECODE: begin
        case (opcode)
          c_opLw, c_opSw: w_nextState = MEMADR;
          c_opR:          w_nextState = EXEC;
          c_opBeq:        w_nextState = BRANCH;
          c_opAddi:       w_nextState = ADDIEX;
          c_opJ:          w_nextState = JUMP;
          default: begin
            w_nextState = FETCH;
            w_badOp     = 1'b1;
          end
        endcase
      end
      MEMADR: w_nextState = (opcode == c_opLw) ? MEMRD : MEMWR;
      MEMRD:  w_nextState = mem_ready ? MEMWB : (w_timeout ? FETCH : MEMRD);
      MEMWR:  w_nextState = (mem_ready || w_timeout) ? FETCH : MEMWR;
      EXEC:   w_nextState = ALUWB;
      ADDIEX: w_nextState = ADDIWB;
      default: w_nextState = FETCH;
    endcase
  end

  assign w_retire = (r_state == MEMWB) || (r_state == ALUWB) || (r_state == BRANCH) ||
                    (r_state == ADDIWB) || (r_state == JUMP) ||
                    (r_state == MEMWR && mem_ready);

  always_comb begin
    pc_write   = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    pc_src     = 2'b00;
    case (r_state)
      FETCH: begin
        if (run) begin
          mem_read  = 1'b1;
          alu_src_b = 2'b01;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
      end
      DECODE: alu_src_b = 2'b11;
      MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      MEMRD: begin
        iord     = 1'b1;
        mem_read = 1'b1;
      end
      MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
      end
      MEMWR: begin
        iord      = 1'b1;
        mem_write = 1'b1;
      end
      EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      ALUWB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
      end
      BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b01;
        pc_src    = 2'b01;
        pc_write  = zero;
      end
      ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      ADDIWB: reg_write = 1'b1;
      JUMP: begin
        pc_src   = 2'b10;
        pc_write = 1'b1;
      end
      default: ;
    endcase
    // The abort cycle drives no strobes at all.
    if (w_timeout) begin
      pc_write  = 1'b0;
      iord      = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      ir_write  = 1'b0;
      alu_src_b = 2'b00;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= FETCH;
      r_waitCnt    <= 8'd0;
      r_instrDone  <= 1'b0;
      r_illegalOp  <= 1'b0;
      r_memTimeout <= 1'b0;
    end else begin
      r_state     <= w_nextState;
      r_waitCnt   <= (w_waiting && !w_timeout) ? r_waitCnt + 8'd1 : 8'd0;
      r_instrDone <= w_retire;
      if (r_state == DECODE && w_badOp) r_illegalOp <= 1'b1;
      if (w_timeout) r_memTimeout <= 1'b1;
    end
  end

  assign state       = r_state;
  assign instr_done  = r_instrDone;
  assign illegal_op  = r_illegalOp;
  assign mem_timeout = r_memTimeout;

endmodule
`default_nettype wire
